sync_fifo_param: RTL

//  Single-clock, parametrised FIFO for buffering within one clock domain.

---
 rtl/sync_fifo_param.sv | 119 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with exact full/empty, occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow error pulses and
// a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned AFULL_TH  = 500,
    parameter int unsigned AEMPTY_TH = 8,
    parameter int unsigned FWFT      = 0
) (
    input  logic              fifo_clk,
    input  logic              rst,
    input  logic              fifo_wr_en,
    input  logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_rd_en,
    output logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_wr_err,
    output logic              fifo_rd_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    // Storage is never reset; only pointers and count define valid contents
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_wr_err;
    logic              r_rd_err;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CNT_W-1:0]  w_count_next;
    logic [DATA_W-1:0] w_head;

    // Accept decisions use the flags registered this cycle
    always_comb begin
        w_wr_acc     = fifo_wr_en & ~r_full;
        w_rd_acc     = fifo_rd_en & ~r_empty;
        w_count_next = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
        w_head       = r_mem[r_rd_ptr];
    end

    // Memory write port; writes are ignored while reset is held
    always_ff @(posedge fifo_clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= fifo_wr_data;
        end
    end

    // Pointers, occupancy and flags, all derived from the next count
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CNT_W'(DEPTH));
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= CNT_W'(AFULL_TH));
            r_aempty <= (w_count_next <= CNT_W'(AEMPTY_TH));
        end
    end

    // Error pulses for rejected requests, visible the cycle after the request
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_err <= fifo_wr_en & r_full;
            r_rd_err <= fifo_rd_en & r_empty;
        end
    end

    // Registered read data: loads the head word on an accepted read, else holds
    always_ff @(posedge fifo_clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_data <= w_head;
        end
    end

    // In FWFT mode the head word is presented directly from the array
    assign fifo_rd_data = (FWFT != 0) ? w_head : r_rd_data;

    assign fifo_full    = r_full;
    assign fifo_empty   = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign fifo_count   = r_count;
    assign fifo_wr_err  = r_wr_err;
    assign fifo_rd_err  = r_rd_err;

endmodule
